// File: rtl/instruction_ram_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes them to the instruction RAM.
// One word per 5 cycles at best (4 byte accepts + 1 write); byte_ready drops during WRITE/DONE and the source must hold.
module instruction_ram_loader #(
    parameter int RAM_BYTES = 4096,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        base_addr,
    input  logic [COUNT_W-1:0] word_count,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic [31:0]        din,
    output logic               write_en,
    output logic [31:0]        waddr,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t             state;
    logic [1:0]         idx;
    logic [COUNT_W-1:0] words_left;
    logic [31:0]        ptr;
    logic [31:0]        word;
    logic [33:0]        end_addr;
    logic               range_ok;

    // 34-bit end address so a base near 4 GiB cannot wrap into a legal range.
    assign end_addr = {2'b00, base_addr} + ({{(34-COUNT_W){1'b0}}, word_count} << 2);
    assign range_ok = (base_addr[1:0] == 2'b00) && (end_addr <= 34'(RAM_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            words_left <= '0;
            ptr        <= 32'd0;
            word       <= 32'd0;
            error      <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!range_ok) begin
                            error <= 1'b1;
                        end else begin
                            error      <= 1'b0;
                            ptr        <= base_addr;
                            words_left <= word_count;
                            idx        <= 2'd0;
                            state      <= (word_count == '0) ? DONE : COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        word[{idx, 3'b000} +: 8] <= byte_in;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    ptr        <= ptr + 32'd4;
                    words_left <= words_left - COUNT_W'(1);
                    idx        <= 2'd0;
                    state      <= (words_left == COUNT_W'(1)) ? DONE : COLLECT;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Abort gates the strobes in the same cycle so the RAM never captures a word being abandoned.
    assign byte_ready = (state == COLLECT);
    assign write_en   = (state == WRITE) && !abort;
    assign done       = (state == DONE) && !abort;
    assign cpu_hold   = (state != IDLE);
    assign din        = word;
    assign waddr      = ptr;

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Directed bench for instruction_ram_loader with RAM_BYTES=1024; a negedge monitor plays the RAM.
module tb_instruction_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [15:0] word_count = 16'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] din;
    logic        write_en;
    logic [31:0] waddr;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_asserts = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [63:0] wr_q[$];
    int          wr_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          hold_cnt = 0;
    int          ready_cnt = 0;
    logic [7:0]  bq[$];

    instruction_ram_loader #(.RAM_BYTES(1024), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .din(din), .write_en(write_en), .waddr(waddr),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (write_en) begin
            wr_q.push_back({waddr, din});
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cpu_hold) hold_cnt++;
        if (byte_ready) ready_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_q.delete();
        wr_cyc.delete();
        done_cnt = 0;
        hold_cnt = 0;
        ready_cnt = 0;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
        start = 1'b1;
        base_addr = base;
        word_count = cnt;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic send_bytes(input int gap, output bit ok);
        int t;
        ok = 1'b1;
        while (bq.size() > 0) begin
            byte_in = bq.pop_front();
            byte_valid = 1'b1;
            t = 0;
            while (!byte_ready && t < 20) begin
                step();
                t++;
            end
            if (!byte_ready) begin
                ok = 1'b0;
                byte_valid = 1'b0;
                bq.delete();
                return;
            end
            step();
            if (gap > 0 && bq.size() > 0) begin
                byte_valid = 1'b0;
                repeat (gap) step();
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        int t;
        t = 0;
        while (done_cnt == 0 && t < max) begin
            step();
            t++;
        end
        ok = (done_cnt != 0);
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        n_asserts++;
        if ({byte_ready, write_en, cpu_hold, done, error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000", {byte_ready, write_en, cpu_hold, done, error});
        end
        n_asserts++;
        if (din !== 32'd0 || waddr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bus: din=%h waddr=%h required 0/0", din, waddr);
        end
    endtask

    task automatic run_two_words(input string tag, input int gap, input bit poke_start);
        bit ok;
        bit dn;
        clear_log();
        do_start(32'h08, 16'd2);
        if (poke_start) begin
            do_start(32'h100, 16'd1);
        end
        bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h08, 8'h10, 8'h00};
        send_bytes(gap, ok);
        wait_done(30, dn);
        n_asserts++;
        if (!ok || !dn) begin
            n_fail++;
            $display("FAIL %s_progress: bytes_ok=%0d done_seen=%0d required 1/1", tag, ok, dn);
        end
        n_asserts++;
        if (wr_q.size() != 2) begin
            n_fail++;
            $display("FAIL %s_wr_count: got %0d required 2", tag, wr_q.size());
        end else begin
            n_asserts++;
            if (wr_q[0] !== {32'h08, 32'h00000013} || wr_q[1] !== {32'h0C, 32'h00100893}) begin
                n_fail++;
                $display("FAIL %s_wr_data: got %h %h required 0000000800000013 0000000c00100893", tag, wr_q[0], wr_q[1]);
            end
            n_asserts++;
            if (done_cyc !== wr_cyc[1] + 1) begin
                n_fail++;
                $display("FAIL %s_done_timing: done cycle %0d required %0d", tag, done_cyc, wr_cyc[1] + 1);
            end
        end
        n_asserts++;
        if (done_cnt != 1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: done_cnt=%0d hold=%b error=%b required 1/0/0", tag, done_cnt, cpu_hold, error);
        end
    endtask

    task automatic test_legal_load();
        run_two_words("legal", 0, 1'b0);
        n_asserts++;
        if (wr_cyc.size() == 2 && (wr_cyc[0] != start_cyc + 5 || wr_cyc[1] != start_cyc + 10)) begin
            n_fail++;
            $display("FAIL legal_wr_timing: writes at +%0d,+%0d required +5,+10", wr_cyc[0] - start_cyc, wr_cyc[1] - start_cyc);
        end
        n_asserts++;
        if (hold_cnt != 11 || done_cyc != start_cyc + 11) begin
            n_fail++;
            $display("FAIL legal_hold: hold cycles %0d done at +%0d required 11 and +11", hold_cnt, done_cyc - start_cyc);
        end
    endtask

    task automatic test_gaps();
        run_two_words("gaps", 3, 1'b1);
    endtask

    task automatic test_range();
        bit ok;
        bit dn;
        clear_log();
        do_start(32'h3F4, 16'd4);
        repeat (3) step();
        n_asserts++;
        if (error !== 1'b1 || cpu_hold !== 1'b0 || ready_cnt != 0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL range_over: error=%b hold=%b ready_cycles=%0d writes=%0d required 1/0/0/0", error, cpu_hold, ready_cnt, wr_q.size());
        end
        clear_log();
        do_start(32'h3F4, 16'd3);
        n_asserts++;
        if (error !== 1'b0 || byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL range_edge_start: error=%b ready=%b required 0/1", error, byte_ready);
        end
        for (int i = 0; i < 12; i++) bq.push_back(8'(i + 1));
        send_bytes(0, ok);
        wait_done(30, dn);
        n_asserts++;
        if (!ok || !dn || wr_q.size() != 3) begin
            n_fail++;
            $display("FAIL range_edge_load: bytes_ok=%0d done=%0d writes=%0d required 1/1/3", ok, dn, wr_q.size());
        end else begin
            n_asserts++;
            if (wr_q[2] !== {32'h3FC, 32'h0C0B0A09} || wr_q[0] !== {32'h3F4, 32'h04030201}) begin
                n_fail++;
                $display("FAIL range_edge_data: first %h last %h required 000003f404030201 000003fc0c0b0a09", wr_q[0], wr_q[2]);
            end
        end
        clear_log();
        do_start(32'h06, 16'd1);
        repeat (3) step();
        n_asserts++;
        if (error !== 1'b1 || cpu_hold !== 1'b0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL range_align: error=%b hold=%b writes=%0d required 1/0/0", error, cpu_hold, wr_q.size());
        end
    endtask

    task automatic test_zero_count();
        clear_log();
        do_start(32'h10, 16'd0);
        repeat (4) step();
        n_asserts++;
        if (done_cnt != 1 || done_cyc < start_cyc + 1 || done_cyc > start_cyc + 2) begin
            n_fail++;
            $display("FAIL zero_done: pulses=%0d at +%0d required 1 pulse at +1..+2", done_cnt, done_cyc - start_cyc);
        end
        n_asserts++;
        if (wr_q.size() != 0 || ready_cnt != 0 || error !== 1'b0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_quiet: writes=%0d ready_cycles=%0d error=%b hold=%b required 0/0/0/0", wr_q.size(), ready_cnt, error, cpu_hold);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit dn;
        clear_log();
        do_start(32'h00, 16'd1);
        bq = '{8'h11, 8'h22};
        send_bytes(0, ok);
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_asserts++;
        if (cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: hold=%b ready=%b required 0/0", cpu_hold, byte_ready);
        end
        repeat (4) step();
        n_asserts++;
        if (wr_q.size() != 0 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: writes=%0d done=%0d required 0/0", wr_q.size(), done_cnt);
        end
        clear_log();
        do_start(32'h20, 16'd1);
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_bytes(0, ok);
        wait_done(20, dn);
        n_asserts++;
        if (wr_q.size() != 1 || !dn) begin
            n_fail++;
            $display("FAIL abort_reload: writes=%0d done=%0d required 1/1", wr_q.size(), dn);
        end else begin
            n_asserts++;
            if (wr_q[0] !== {32'h20, 32'hDDCCBBAA}) begin
                n_fail++;
                $display("FAIL abort_reload_data: got %h required 00000020ddccbbaa", wr_q[0]);
            end
        end
        clear_log();
        do_start(32'h40, 16'd1);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes(0, ok);
        abort = 1'b1;
        #1;
        n_asserts++;
        if (write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_write: write_en=%b required 0", write_en);
        end
        step();
        abort = 1'b0;
        step();
        n_asserts++;
        if (wr_q.size() != 0 || cpu_hold !== 1'b0 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_write_quiet: writes=%0d hold=%b done=%0d required 0/0/0", wr_q.size(), cpu_hold, done_cnt);
        end
        clear_log();
        abort = 1'b1;
        do_start(32'h00, 16'd1);
        abort = 1'b0;
        step();
        n_asserts++;
        if (cpu_hold !== 1'b0 || ready_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_beats_start: hold=%b ready_cycles=%0d required 0/0", cpu_hold, ready_cnt);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        bit dn;
        clear_log();
        do_start(32'h80, 16'd2);
        bq = '{8'h55, 8'h66, 8'h77, 8'h88};
        send_bytes(0, ok);
        #1;
        n_asserts++;
        if (write_en !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre_write: write_en=%b required 1", write_en);
        end
        rst_n = 1'b0;
        #1;
        n_asserts++;
        if ({byte_ready, write_en, cpu_hold, done, error} !== 5'b0 || din !== 32'd0 || waddr !== 32'd0) begin
            n_fail++;
            $display("FAIL arst_outputs: flags=%b din=%h waddr=%h required 00000/0/0", {byte_ready, write_en, cpu_hold, done, error}, din, waddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_asserts++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL arst_no_write: writes=%0d required 0", wr_q.size());
        end
        clear_log();
        do_start(32'h3DC, 16'd1);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes(0, ok);
        wait_done(20, dn);
        n_asserts++;
        if (wr_q.size() != 1 || !dn) begin
            n_fail++;
            $display("FAIL arst_reload: writes=%0d done=%0d required 1/1", wr_q.size(), dn);
        end else begin
            n_asserts++;
            if (wr_q[0] !== {32'h3DC, 32'h04030201}) begin
                n_fail++;
                $display("FAIL arst_reload_data: got %h required 000003dc04030201", wr_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal_load();
        test_gaps();
        test_range();
        test_zero_count();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
